pulse_width_meter: RTL and testbench

//  Consumes the level already synchronised into the clk2 domain by the slow-to-fast CDC stage.

---
 rtl/pwm_meas_pkg.sv | 11 +
 rtl/pulse_width_meter_if.sv | 14 +
 rtl/edge_det.sv | 24 ++
 rtl/pulse_width_meter.sv | 81 ++++++++
 tb/tb_pulse_width_meter.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/pwm_meas_pkg.sv
// pwm_meas_pkg: shared FSM state, saturation limit and result record for the pulse width meter
package pwm_meas_pkg;
  localparam int MAX_CNT_W = 16;
  localparam logic [MAX_CNT_W-1:0] CNT_MAX = '1;
  typedef enum logic {IDLE, MEAS} state_t;
  typedef struct packed {
    logic                 level;
    logic                 ovf;
    logic [MAX_CNT_W-1:0] width;
  } result_t;
endpackage

// File: rtl/pulse_width_meter_if.sv
// pulse_width_meter_if: measurement result port with valid/ready handshake and drop counter
interface pulse_width_meter_if #(
  parameter int CNT_W  = 16,
  parameter int DROP_W = 8
);
  logic              meas_valid;
  logic              meas_ready;
  logic              meas_level;
  logic              meas_ovf;
  logic [CNT_W-1:0]  meas_width;
  logic [DROP_W-1:0] drop_cnt;
  modport master (output meas_valid, meas_level, meas_ovf, meas_width, drop_cnt, input meas_ready);
  modport slave  (input meas_valid, meas_level, meas_ovf, meas_width, drop_cnt, output meas_ready);
endinterface

// File: rtl/edge_det.sv
// edge_det: registers the level once and produces registered rise/fall pulses
module edge_det (
  input  logic clk2,
  input  logic rst_n,
  input  logic clr,
  input  logic sig_in,
  output logic sig_d,
  output logic tog,
  output logic edge_rise,
  output logic edge_fall
);
  assign tog = sig_in ^ sig_d;
  // Delay the level and register the pulses; clr keeps tracking the level so no false edge follows it
  always_ff @(posedge clk2 or negedge rst_n)
    if (!rst_n) begin
      sig_d     <= 1'b0;
      edge_rise <= 1'b0;
      edge_fall <= 1'b0;
    end else begin
      sig_d     <= sig_in;
      edge_rise <= !clr && sig_in && !sig_d;
      edge_fall <= !clr && !sig_in && sig_d;
    end
endmodule

// File: rtl/pulse_width_meter.sv
// pulse_width_meter: measures high/low segment widths of a synchronised level in clk2 cycles
module pulse_width_meter
  import pwm_meas_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int DROP_W = 8
) (
  input  logic clk2,
  input  logic rst_n,
  input  logic sig_in,
  input  logic clr,
  output logic edge_rise,
  output logic edge_fall,
  pulse_width_meter_if.master m
);
  localparam logic [CNT_W-1:0]  SAT      = CNT_MAX[CNT_W-1:0];
  localparam logic [DROP_W-1:0] DROP_MAX = '1;
  state_t            state, state_nx;
  logic              sig_d, tog, res_v, load, ovf_flag, valid_q;
  logic [CNT_W-1:0]  cnt;
  logic [DROP_W-1:0] drop_q;
  result_t           res, out_q;
  edge_det u_edge (
    .clk2      (clk2),
    .rst_n     (rst_n),
    .clr       (clr),
    .sig_in    (sig_in),
    .sig_d     (sig_d),
    .tog       (tog),
    .edge_rise (edge_rise),
    .edge_fall (edge_fall)
  );
  // State register
  always_ff @(posedge clk2 or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Next state: the first edge starts measuring, clr returns to IDLE
  always_comb state_nx = clr ? IDLE : tog ? MEAS : state;
  // Result decode: every edge seen while measuring closes a segment
  always_comb begin
    res_v = state == MEAS && tog && !clr;
    load  = res_v && (!valid_q || m.meas_ready);
    res   = '{level: sig_d, ovf: ovf_flag, width: MAX_CNT_W'(cnt)};
  end
  // Segment counter restarts at 1 on each edge and saturates, flagging overflow
  always_ff @(posedge clk2 or negedge rst_n)
    if (!rst_n) begin
      cnt      <= '0;
      ovf_flag <= 1'b0;
    end else if (clr) begin
      cnt      <= '0;
      ovf_flag <= 1'b0;
    end else if (tog) begin
      cnt      <= CNT_W'(1);
      ovf_flag <= 1'b0;
    end else if (state == MEAS && cnt != SAT) begin
      cnt      <= cnt + CNT_W'(1);
      ovf_flag <= cnt + CNT_W'(1) == SAT;
    end
  // Output holding register; results arriving while it is stalled are counted as drops
  always_ff @(posedge clk2 or negedge rst_n)
    if (!rst_n) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      drop_q  <= '0;
    end else if (clr) begin
      valid_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      if (load) begin
        valid_q <= 1'b1;
        out_q   <= res;
      end else if (m.meas_ready) valid_q <= 1'b0;
      if (res_v && !load && drop_q != DROP_MAX) drop_q <= drop_q + DROP_W'(1);
    end
  assign m.meas_valid = valid_q;
  assign m.meas_level = out_q.level;
  assign m.meas_ovf   = out_q.ovf;
  assign m.meas_width = out_q.width[CNT_W-1:0];
  assign m.drop_cnt   = drop_q;
endmodule

// File: tb/tb_pulse_width_meter.sv
// tb_pulse_width_meter: directed stimulus against a timestamp-based model, two counter widths
module tb_pulse_width_meter;
  logic clk2 = 1'b0, rst_n, sig_in, clr, ready;
  logic rise16, fall16, rise4, fall4;
  int checks = 0, passes = 0;
  pulse_width_meter_if #(.CNT_W(16), .DROP_W(8)) bus16 ();
  pulse_width_meter_if #(.CNT_W(4),  .DROP_W(8)) bus4 ();
  assign bus16.meas_ready = ready;
  assign bus4.meas_ready  = ready;
  pulse_width_meter #(.CNT_W(16), .DROP_W(8)) dut (
    .clk2(clk2), .rst_n(rst_n), .sig_in(sig_in), .clr(clr),
    .edge_rise(rise16), .edge_fall(fall16), .m(bus16)
  );
  pulse_width_meter #(.CNT_W(4), .DROP_W(8)) dut4 (
    .clk2(clk2), .rst_n(rst_n), .sig_in(sig_in), .clr(clr),
    .edge_rise(rise4), .edge_fall(fall4), .m(bus4)
  );
  always #10 clk2 = ~clk2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [17:0] r16(input logic l, input logic o, input int w);
    return {l, o, 16'(w)};
  endfunction

  function automatic logic [5:0] r4(input logic l, input logic o, input int w);
    return {l, o, 4'(w)};
  endfunction

  // Model: segment width is the cycle distance between consecutive edges; first edge after reset/clr is unmeasured
  int   cyc, last_edge, e_dur, e_drop;
  logic sig_q, e_valid, e_lvl, e_rise, e_fall;
  always @(posedge clk2 or negedge rst_n)
    if (!rst_n) begin
      cyc <= 0; last_edge <= -1; sig_q <= 1'b0; e_valid <= 1'b0; e_lvl <= 1'b0;
      e_dur <= 0; e_drop <= 0; e_rise <= 1'b0; e_fall <= 1'b0;
    end else if (clr) begin
      cyc <= cyc + 1; last_edge <= -1; sig_q <= sig_in; e_valid <= 1'b0;
      e_drop <= 0; e_rise <= 1'b0; e_fall <= 1'b0;
    end else begin
      cyc    <= cyc + 1;
      sig_q  <= sig_in;
      e_rise <= sig_in && !sig_q;
      e_fall <= !sig_in && sig_q;
      if (sig_in != sig_q) last_edge <= cyc;
      if (sig_in != sig_q && last_edge >= 0 && e_valid && !ready) e_drop <= e_drop < 255 ? e_drop + 1 : e_drop;
      else if (sig_in != sig_q && last_edge >= 0) begin
        e_valid <= 1'b1;
        e_lvl   <= sig_q;
        e_dur   <= cyc - last_edge;
      end else if (ready) e_valid <= 1'b0;
    end

  // Compare both DUTs against the model every cycle
  always @(negedge clk2) begin
    chk("valid16", bus16.meas_valid, e_valid);
    chk("drop16", bus16.drop_cnt, 8'(e_drop));
    chk("rise16", rise16, e_rise);
    chk("fall16", fall16, e_fall);
    chk("valid4", bus4.meas_valid, e_valid);
    chk("drop4", bus4.drop_cnt, 8'(e_drop));
    chk("rise4", rise4, e_rise);
    chk("fall4", fall4, e_fall);
    if (e_valid) begin
      chk("res16", {bus16.meas_level, bus16.meas_ovf, bus16.meas_width},
          r16(e_lvl, e_dur >= 65535, e_dur > 65535 ? 65535 : e_dur));
      chk("res4", {bus4.meas_level, bus4.meas_ovf, bus4.meas_width},
          r4(e_lvl, e_dur >= 15, e_dur > 15 ? 15 : e_dur));
    end
  end

  // Record every accepted result
  logic [17:0] q16[$];
  logic [5:0]  q4[$];
  always @(posedge clk2)
    if (rst_n && !clr && ready) begin
      if (bus16.meas_valid) q16.push_back({bus16.meas_level, bus16.meas_ovf, bus16.meas_width});
      if (bus4.meas_valid) q4.push_back({bus4.meas_level, bus4.meas_ovf, bus4.meas_width});
    end

  task automatic drive(input logic s, input int n);
    sig_in = s;
    repeat (n) @(negedge clk2);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out16"}, {bus16.meas_valid, bus16.meas_level, bus16.meas_ovf, bus16.meas_width, bus16.drop_cnt, rise16, fall16}, 0);
    chk({tag, "_out4"}, {bus4.meas_valid, bus4.meas_level, bus4.meas_ovf, bus4.meas_width, bus4.drop_cnt, rise4, fall4}, 0);
  endtask

  logic [17:0] exp16[17];
  initial begin
    exp16 = '{r16(1,0,20), r16(0,0,4), r16(1,0,20), r16(0,0,4), r16(1,0,20),
              r16(0,0,6), r16(1,0,30), r16(0,0,3),
              r16(1,0,4), r16(0,0,1), r16(1,0,1), r16(0,0,1), r16(1,0,1), r16(0,0,1),
              r16(1,0,4), r16(1,0,4), r16(0,0,6)};
    rst_n = 1'b0; sig_in = 1'b0; clr = 1'b0; ready = 1'b1;
    repeat (3) @(negedge clk2);
    chk_zero("reset");
    rst_n = 1'b1;
    drive(0, 2);
    for (int i = 0; i < 3; i++) begin
      drive(1, 20);
      drive(0, i == 2 ? 3 : 4);
    end
    ready = 1'b0;
    drive(0, 3);
    drive(1, 5);
    drive(0, 3);
    drive(1, 2);
    chk("bp_valid", bus16.meas_valid, 1);
    chk("bp_hold", {bus16.meas_level, bus16.meas_ovf, bus16.meas_width}, r16(0, 0, 6));
    chk("bp_drop", bus16.drop_cnt, 2);
    ready = 1'b1;
    drive(1, 1);
    chk("bp_release", bus16.meas_valid, 0);
    drive(1, 27);
    drive(0, 3);
    drive(1, 4);
    for (int i = 0; i < 6; i++) drive(i % 2, 1);
    drive(1, 5);
    chk("toggle_drop", bus16.drop_cnt, 2);
    ready = 1'b0;
    drive(0, 3);
    chk("pre_clr_hold", {bus16.meas_valid, bus16.meas_level, bus16.meas_ovf, bus16.meas_width}, {1'b1, r16(1, 0, 6)});
    clr = 1'b1;
    drive(0, 1);
    clr = 1'b0;
    chk("clr_valid", bus16.meas_valid, 0);
    chk("clr_drop", bus16.drop_cnt, 0);
    ready = 1'b1;
    drive(0, 2);
    drive(1, 4);
    drive(0, 2);
    ready = 1'b0;
    drive(0, 3);
    drive(1, 3);
    chk("pre_rst_hold", {bus16.meas_valid, bus16.meas_level, bus16.meas_ovf, bus16.meas_width}, {1'b1, r16(0, 0, 5)});
    #3 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk2);
    ready = 1'b1;
    rst_n = 1'b1;
    drive(1, 4);
    drive(0, 6);
    drive(1, 5);
    chk("acc16_count", q16.size(), 17);
    for (int i = 0; i < 17 && i < q16.size(); i++) chk($sformatf("acc16_%0d", i), q16[i], exp16[i]);
    chk("acc4_count", q4.size(), 17);
    if (q4.size() >= 8) begin
      chk("acc4_first", q4[0], r4(1, 1, 15));
      chk("acc4_low", q4[1], r4(0, 0, 4));
      chk("acc4_sat", q4[6], r4(1, 1, 15));
      chk("acc4_after_sat", q4[7], r4(0, 0, 3));
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
